// File: rtl/fuel_dispenser_ctrl.sv
// Fuel dispenser transaction controller: arm on a start edge, meter units at TICK_DIV cycles each, stop at the prepaid amount.
// Optional build macro PAUSE_TIMEOUT_EN ends a transaction after IDLE_TIMEOUT consecutive paused cycles.
module fuel_dispenser_ctrl #(
  parameter int N_FUEL       = 3,
  parameter int AMT_W        = 24,
  parameter int VOL_W        = 20,
  parameter int PRICE_W      = 16,
  parameter logic [N_FUEL*PRICE_W-1:0] PRICES = {16'd190, 16'd210, 16'd230},
  parameter int TICK_DIV     = 1000,
  parameter int IDLE_TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              valve,
  input  logic [2:0]        select,
  input  logic [AMT_W-1:0]  keyboard,
  output logic [N_FUEL-1:0] gas,
  output logic [AMT_W-1:0]  money,
  output logic [VOL_W-1:0]  volume,
  output logic [2:0]        grade,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_FILL  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  state_t              state, state_n;
  logic                start_q, seen_low;
  logic [2:0]          sel_q, sel_n;
  logic [AMT_W-1:0]    preset_q, preset_n;
  logic [TW-1:0]       tick, tick_n;
  logic [AMT_W-1:0]    money_n;
  logic [VOL_W-1:0]    volume_n, vol_inc;
  logic [PRICE_W-1:0]  price;
  logic [N_FUEL-1:0]   gas_mask;
  logic [AMT_W:0]      sum;
  logic                rise, sel_ok, tick_last;

`ifdef PAUSE_TIMEOUT_EN
  localparam int TOW = $clog2(IDLE_TIMEOUT + 1);
  logic [TOW-1:0] to_cnt, to_cnt_n;
  logic           to_expired;
  assign to_expired = (to_cnt == TOW'(IDLE_TIMEOUT - 1));
`endif

  assign dbg_state = state;

  // seen_low blocks a start that was already high when reset released.
  assign rise      = start & ~start_q & seen_low;
  assign sel_ok    = (select != 3'd0) && (select <= 3'(N_FUEL));
  assign tick_last = (tick == TW'(TICK_DIV - 1));
  assign vol_inc   = (volume == '1) ? volume : volume + 1'b1;
  assign sum       = {1'b0, money} + (AMT_W+1)'(price);

  always_comb begin
    price    = '0;
    gas_mask = '0;
    for (int i = 0; i < N_FUEL; i++) begin
      if (sel_q == 3'(i + 1)) begin
        price       = PRICES[i*PRICE_W +: PRICE_W];
        gas_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    sel_n    = sel_q;
    preset_n = preset_q;
    tick_n   = tick;
    money_n  = money;
    volume_n = volume;
    case (state)
      S_IDLE: begin
        if (rise && sel_ok && (keyboard != '0)) begin
          state_n  = S_ARMED;
          sel_n    = select;
          preset_n = keyboard;
          money_n  = '0;
          volume_n = '0;
          tick_n   = '0;
        end
      end
      S_ARMED: begin
        if (!start)     state_n = S_DONE;
        else if (valve) state_n = S_FILL;
      end
      S_FILL: begin
        // Fuel flows in every FILL cycle, so the tick advances even when valve just dropped.
        if (!start) begin
          state_n = S_DONE;
        end else begin
          state_n = valve ? S_FILL : S_PAUSE;
          if (tick_last) begin
            tick_n   = '0;
            volume_n = vol_inc;
            if (sum >= {1'b0, preset_q}) begin
              money_n = preset_q;
              state_n = S_DONE;
            end else begin
              money_n = sum[AMT_W-1:0];
            end
          end else begin
            tick_n = tick + 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (!start)     state_n = S_DONE;
        else if (valve) state_n = S_FILL;
`ifdef PAUSE_TIMEOUT_EN
        else if (to_expired) state_n = S_DONE;
`endif
      end
      S_DONE: begin
        if (!start) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

`ifdef PAUSE_TIMEOUT_EN
  always_comb begin
    to_cnt_n = '0;
    if (state == S_PAUSE && state_n == S_PAUSE) to_cnt_n = to_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) to_cnt <= '0;
    else       to_cnt <= to_cnt_n;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      start_q  <= 1'b0;
      seen_low <= 1'b0;
      sel_q    <= '0;
      preset_q <= '0;
      tick     <= '0;
      money    <= '0;
      volume   <= '0;
      grade    <= '0;
      gas      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      start_q  <= start;
      seen_low <= seen_low | ~start;
      sel_q    <= sel_n;
      preset_q <= preset_n;
      tick     <= tick_n;
      money    <= money_n;
      volume   <= volume_n;
      grade    <= (state_n == S_IDLE) ? 3'd0 : sel_n;
      gas      <= (state_n == S_FILL) ? gas_mask : '0;
      busy     <= (state_n == S_ARMED) || (state_n == S_FILL) || (state_n == S_PAUSE);
      done     <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_fuel_dispenser_ctrl.sv
// Directed bench for fuel_dispenser_ctrl: a vector table of whole transactions plus hand sequences
// for pause/resume, cancel priority, pause timeout and reset mid-fill.
module tb_fuel_dispenser_ctrl;

  localparam int AMT_W = 24;
  localparam int VOL_W = 20;
  localparam int NF    = 3;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_FILL  = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             valve;
  logic [2:0]       select;
  logic [AMT_W-1:0] keyboard;
  logic [NF-1:0]    gas;
  logic [AMT_W-1:0] money;
  logic [VOL_W-1:0] volume;
  logic [2:0]       grade;
  logic             busy;
  logic             done;
  logic [2:0]       dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  fuel_dispenser_ctrl #(
    .N_FUEL(NF), .AMT_W(AMT_W), .VOL_W(VOL_W), .PRICE_W(16),
    .TICK_DIV(4), .IDLE_TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .valve(valve),
    .select(select), .keyboard(keyboard), .gas(gas), .money(money),
    .volume(volume), .grade(grade), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver: advance n active edges and land 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".gas"},    32'(gas),       0);
    chk({tag, ".money"},  32'(money),     0);
    chk({tag, ".volume"}, 32'(volume),    0);
    chk({tag, ".grade"},  32'(grade),     0);
    chk({tag, ".busy"},   32'(busy),      0);
    chk({tag, ".done"},   32'(done),      0);
    chk({tag, ".state"},  32'(dbg_state), 32'(ST_IDLE));
  endtask

  typedef struct {
    logic [2:0]       sel;
    logic [AMT_W-1:0] kb;
    int               fill_steps;
    logic             chk_money;
    logic [AMT_W-1:0] exp_money;
    logic [VOL_W-1:0] exp_vol;
    logic             exp_done;
    logic             exp_busy;
    logic [NF-1:0]    exp_gas;
    logic [2:0]       exp_grade;
  } vec_t;

  vec_t vecs[9];

  initial begin
    // grade 1 = 230, grade 2 = 210, grade 3 = 190; one unit per 4 FILL cycles
    vecs[0] = '{3'd1, 24'd1000, 20, 1'b1, 24'd1000, 20'd5, 1'b1, 1'b0, 3'b000, 3'd1};
    vecs[1] = '{3'd1, 24'd690,  12, 1'b1, 24'd690,  20'd3, 1'b1, 1'b0, 3'b000, 3'd1};
    vecs[2] = '{3'd2, 24'd1000,  8, 1'b1, 24'd420,  20'd2, 1'b0, 1'b1, 3'b010, 3'd2};
    vecs[3] = '{3'd3, 24'd100,   4, 1'b1, 24'd100,  20'd1, 1'b1, 1'b0, 3'b000, 3'd3};
    vecs[4] = '{3'd1, 24'd1000,  4, 1'b1, 24'd230,  20'd1, 1'b0, 1'b1, 3'b001, 3'd1};
    vecs[5] = '{3'd2, 24'd420,   8, 1'b1, 24'd420,  20'd2, 1'b1, 1'b0, 3'b000, 3'd2};
    vecs[6] = '{3'd0, 24'd500,   4, 1'b0, 24'd0,    20'd0, 1'b0, 1'b0, 3'b000, 3'd0};
    vecs[7] = '{3'd4, 24'd500,   4, 1'b0, 24'd0,    20'd0, 1'b0, 1'b0, 3'b000, 3'd0};
    vecs[8] = '{3'd1, 24'd0,     4, 1'b0, 24'd0,    20'd0, 1'b0, 1'b0, 3'b000, 3'd0};

    reset = 1'b1; start = 1'b0; valve = 1'b0; select = '0; keyboard = '0;
    step(2);
    chk_all_zero("reset");
    reset = 1'b0;
    step(1);

    // money climbs one price per unit and clamps to the preset; later select/keyboard ignored
    select = 3'd1; keyboard = 24'd1000; start = 1'b1;
    step(1);
    chk("units.armed_state", 32'(dbg_state), 32'(ST_ARMED));
    chk("units.armed_gas",   32'(gas), 0);
    chk("units.armed_grade", 32'(grade), 1);
    select = 3'd3; keyboard = 24'd50; valve = 1'b1;
    step(1);
    chk("units.fill_gas", 32'(gas), 32'(3'b001));
    for (int u = 1; u <= 5; u++) begin
      step(4);
      chk($sformatf("units.money%0d", u), 32'(money), (230 * u > 1000) ? 1000 : 230 * u);
      chk($sformatf("units.volume%0d", u), 32'(volume), 32'(u));
    end
    chk("units.done", 32'(done), 1);
    chk("units.done_gas", 32'(gas), 0);
    chk("units.done_busy", 32'(busy), 0);
    step(3);
    chk("units.hold_money", 32'(money), 1000);
    start = 1'b0;
    step(1);
    chk("units.idle_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("units.idle_grade", 32'(grade), 0);
    chk("units.idle_money", 32'(money), 1000);
    chk("units.idle_volume", 32'(volume), 5);
    chk("units.idle_done", 32'(done), 0);

    // vector table: whole transactions and rejected requests
    for (int v = 0; v < 9; v++) begin
      start = 1'b0; valve = 1'b0;
      step(2);
      select = vecs[v].sel; keyboard = vecs[v].kb; start = 1'b1;
      step(1);
      valve = 1'b1;
      step(1);
      step(vecs[v].fill_steps);
      if (vecs[v].chk_money) begin
        chk($sformatf("vec%0d.money", v), 32'(money), 32'(vecs[v].exp_money));
        chk($sformatf("vec%0d.volume", v), 32'(volume), 32'(vecs[v].exp_vol));
      end
      chk($sformatf("vec%0d.done", v), 32'(done), 32'(vecs[v].exp_done));
      chk($sformatf("vec%0d.busy", v), 32'(busy), 32'(vecs[v].exp_busy));
      chk($sformatf("vec%0d.gas", v), 32'(gas), 32'(vecs[v].exp_gas));
      chk($sformatf("vec%0d.grade", v), 32'(grade), 32'(vecs[v].exp_grade));
    end

    // pause after two units keeps the partial tick count and holds money
    start = 1'b0; valve = 1'b0;
    step(2);
    select = 3'd1; keyboard = 24'd1000; start = 1'b1;
    step(1);
    valve = 1'b1;
    step(1);
    step(8);
    chk("pause.money_before", 32'(money), 460);
    valve = 1'b0;
    step(1);
    chk("pause.state", 32'(dbg_state), 32'(ST_PAUSE));
    chk("pause.gas", 32'(gas), 0);
`ifdef PAUSE_TIMEOUT_EN
    step(5);
`else
    step(20);
`endif
    chk("pause.held_state", 32'(dbg_state), 32'(ST_PAUSE));
    chk("pause.held_money", 32'(money), 460);
    chk("pause.held_gas", 32'(gas), 0);
    valve = 1'b1;
    step(1);
    chk("pause.resume_gas", 32'(gas), 32'(3'b001));
    step(2);
    chk("pause.resume_money_early", 32'(money), 460);
    step(1);
    chk("pause.resume_money", 32'(money), 690);
    chk("pause.resume_volume", 32'(volume), 3);
    // cancel on the very cycle a unit would complete: nothing is counted
    step(3);
    start = 1'b0;
    step(1);
    chk("cancel.state", 32'(dbg_state), 32'(ST_DONE));
    chk("cancel.money", 32'(money), 690);
    chk("cancel.volume", 32'(volume), 3);

    // unit completion and valve drop in the same cycle: count it, then pause
    step(2);
    select = 3'd2; keyboard = 24'd1000; start = 1'b1;
    step(1);
    valve = 1'b1;
    step(1);
    step(3);
    valve = 1'b0;
    step(1);
    chk("tickdrop.money", 32'(money), 210);
    chk("tickdrop.volume", 32'(volume), 1);
    chk("tickdrop.state", 32'(dbg_state), 32'(ST_PAUSE));
    chk("tickdrop.gas", 32'(gas), 0);
`ifdef PAUSE_TIMEOUT_EN
    step(7);
    chk("timeout.before_state", 32'(dbg_state), 32'(ST_PAUSE));
    step(1);
    chk("timeout.done", 32'(done), 1);
    chk("timeout.money", 32'(money), 210);
`else
    step(30);
    chk("notimeout.state", 32'(dbg_state), 32'(ST_PAUSE));
    chk("notimeout.busy", 32'(busy), 1);
    chk("notimeout.money", 32'(money), 210);
`endif
    start = 1'b0;
    step(2);

    // cancel straight from ARMED
    select = 3'd3; keyboard = 24'd500; start = 1'b1;
    step(1);
    chk("armcancel.armed", 32'(dbg_state), 32'(ST_ARMED));
    chk("armcancel.money_cleared", 32'(money), 0);
    start = 1'b0;
    step(1);
    chk("armcancel.done", 32'(done), 1);
    chk("armcancel.volume", 32'(volume), 0);
    step(1);
    chk("armcancel.idle", 32'(dbg_state), 32'(ST_IDLE));

    // asynchronous reset mid-fill with start held high
    select = 3'd1; keyboard = 24'd1000; start = 1'b1;
    step(1);
    valve = 1'b1;
    step(1);
    step(6);
    chk("rstfill.money", 32'(money), 230);
    reset = 1'b1;
    #1;
    chk_all_zero("rstfill.async");
    step(2);
    reset = 1'b0;
    step(10);
    chk("rstfill.no_restart_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rstfill.no_restart_busy", 32'(busy), 0);
    chk("rstfill.no_restart_gas", 32'(gas), 0);
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    chk("rstfill.retry_state", 32'(dbg_state), 32'(ST_ARMED));
    chk("rstfill.retry_busy", 32'(busy), 1);
    chk("rstfill.retry_grade", 32'(grade), 1);
    start = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
